// File: rtl/seg7_octal_scan.sv
// seg7_octal_scan
//   Multiplexed 4-digit 7-segment driver showing a 48-bit BESM-6 word as
//   16 octal digits, one 4-digit window at a time. The word is captured on
//   a load strobe; two debounced push buttons step the window.
//
// Ports:
//   clk       system clock (100 MHz)
//   rst_n     asynchronous active-low reset
//   value     48-bit word, captured while load=1
//   load      snapshot strobe
//   btn_next  raw button, window + 1 (mod 4)
//   btn_prev  raw button, window - 1 (mod 4)
//   seg       segments a..g on seg[0]..seg[6], active low, registered
//   dp        decimal point, active low, registered; lit on the digit whose
//             position equals the window number
//   an        digit anodes, active low, an[0] rightmost, registered
//   window    current window index
//
// Optional feature: define SEG7_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked, dp is unaffected).
module seg7_octal_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEBOUNCE    = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] value,
    input  logic        load,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [1:0]  window
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [47:0]   snap;
    logic [RW-1:0] slot_cnt;
    logic [1:0]    pos;

    // Button conditioning; bit 0 = next, bit 1 = prev.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    accepted;
    logic [1:0]    accepted_d;
    logic [DW-1:0] db_cnt [2];
    logic [1:0]    pulse;

    logic [3:0]    idx;
    logic [5:0]    shamt;
    logic [2:0]    digit;
    logic [6:0]    pattern;
    logic          blank;
    logic [15:0]   lead_zero;

    // Snapshot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (load) begin
            snap <= value;
        end
    end

    // Synchronizer + debounce. The counter only advances while the
    // synchronized level disagrees with the accepted one, so any return to
    // the accepted level before DEBOUNCE cycles restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            accepted   <= '0;
            accepted_d <= '0;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            sync1      <= {btn_prev, btn_next};
            sync2      <= sync1;
            accepted_d <= accepted;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == accepted[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    accepted[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pulse = accepted & ~accepted_d;

    // Window index; simultaneous next/prev pulses cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
        end else if (pulse[0] && !pulse[1]) begin
            window <= window + 2'd1;
        end else if (pulse[1] && !pulse[0]) begin
            window <= window - 2'd1;
        end
    end

    // Slot counter and digit position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            pos      <= '0;
        end else if (slot_cnt == RW'(REFRESH_DIV - 1)) begin
            slot_cnt <= '0;
            pos      <= pos + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Digit selection: digit index is 4*window + pos, bit offset 3*index.
    always_comb begin
        idx   = {window, pos};
        shamt = {1'b0, idx, 1'b0} + {2'b00, idx};
        digit = snap[shamt +: 3];
    end

    // lead_zero[k]: digit k and all more-significant digits are zero.
    always_comb begin
        lead_zero     = '0;
        lead_zero[15] = (snap[47:45] == 3'd0);
        for (int unsigned i = 0; i < 15; i++) begin
            lead_zero[14 - i] = lead_zero[15 - i] && (snap[3 * (14 - i) +: 3] == 3'd0);
        end
    end

`ifdef SEG7_ZERO_BLANK_EN
    assign blank = lead_zero[idx] && (idx != 4'd0);
`else
    assign blank = 1'b0;
`endif

    // Active-low gfedcba patterns for octal digits
    always_comb begin
        pattern = 7'h7F;
        case (digit)
            3'd0: pattern = 7'b1000000;
            3'd1: pattern = 7'b1111001;
            3'd2: pattern = 7'b0100100;
            3'd3: pattern = 7'b0110000;
            3'd4: pattern = 7'b0011001;
            3'd5: pattern = 7'b0010010;
            3'd6: pattern = 7'b0000010;
            3'd7: pattern = 7'b1111000;
            default: pattern = 7'h7F;
        endcase
    end

    // Registered outputs, all derived from the same pos. Count 0 of each
    // slot turns every anode off to avoid ghosting between digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= 4'hF;
        end else begin
            seg <= blank ? 7'h7F : pattern;
            dp  <= (pos != window);
            an  <= (slot_cnt == '0) ? 4'hF : ~(4'b0001 << pos);
        end
    end

endmodule

// File: tb/tb_seg7_octal_scan.sv
module tb_seg7_octal_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] value;
    logic        load;
    logic        btn_next;
    logic        btn_prev;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  window;

    always #5 clk = ~clk;

    seg7_octal_scan #(
        .REFRESH_DIV(4),
        .DEBOUNCE(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value(value),
        .load(load),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .seg(seg),
        .dp(dp),
        .an(an),
        .window(window)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] prev_an = 4'hF;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'h7F;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares at the first lit cycle of every slot while
    // expectations are queued.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && prev_an == 4'hF && an != 4'hF && q.size() > 0) begin
            e = q.pop_front();
            chk("slot_an", {44'd0, an}, {44'd0, e.an});
            chk("slot_seg", {41'd0, seg}, {41'd0, e.seg});
            chk("slot_dp", {47'd0, dp}, {47'd0, e.dp});
        end
        prev_an = an;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] v);
        int n = 0;
        while (an !== v && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (an !== v) chk("wait_an_timeout", {44'd0, an}, {44'd0, v});
    endtask

    // Queue expectations for the next p=0..3 pass (an[0]..an[3]).
    task automatic push_slots(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input int unsigned dpos);
        exp_t x;
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        wait_an(4'b0111);
        tick(1);
        for (int j = 0; j < 4; j++) begin
            x.an  = ~(4'b0001 << j);
            x.seg = s[j];
            x.dp  = (j != int'(dpos));
            q.push_back(x);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", 48'(q.size()), 48'd0);
            q.delete();
        end
    endtask

    task automatic do_load(input logic [47:0] v);
        value = v;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    task automatic press(input bit nxt, input bit prv);
        btn_next = nxt;
        btn_prev = prv;
        tick(12);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(12);
    endtask

    initial begin
        int ok;
        rst_n    = 1'b0;
        value    = '0;
        load     = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(3);
        chk("reset_seg", {41'd0, seg}, {41'd0, 7'h7F});
        chk("reset_dp", {47'd0, dp}, 48'd1);
        chk("reset_an", {44'd0, an}, 48'hF);
        chk("reset_window", {46'd0, window}, 48'd0);

        rst_n = 1'b1;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (an == 4'b1110) ok = 1;
        end
        chk("reset_release_an", 48'(ok), 48'd1);

        // Anti-ghosting: a lit slot is preceded by exactly one blank cycle
        wait_an(4'b1101);
        wait_an(4'hF);
        tick(1);
        chk("blank_one_cycle", {44'd0, an}, 48'b1011);

        // Window 0 scan
        do_load(48'o0000_0000_0000_7654);
        push_slots(S4, S5, S6, S7, 0);
        drain();

        // Wrap 0 -> 3 on prev
        do_load(48'o1234_0000_0000_0000);
        press(1'b0, 1'b1);
        chk("wrap_prev_window", {46'd0, window}, 48'd3);
        push_slots(S4, S3, S2, S1, 3);
        drain();

        // Wrap 3 -> 0 on next
        press(1'b1, 1'b0);
        chk("wrap_next_window", {46'd0, window}, 48'd0);

        // Bounce: toggling every 2 cycles never qualifies
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            tick(2);
        end
        btn_next = 1'b0;
        tick(12);
        chk("bounce_window", {46'd0, window}, 48'd0);

        // Held button: one increment only
        btn_next = 1'b1;
        tick(50);
        chk("hold_window", {46'd0, window}, 48'd1);
        btn_next = 1'b0;
        tick(12);
        chk("release_window", {46'd0, window}, 48'd1);

        // Simultaneous buttons cancel
        btn_next = 1'b1;
        btn_prev = 1'b1;
        tick(30);
        chk("both_held_window", {46'd0, window}, 48'd1);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(12);
        chk("both_release_window", {46'd0, window}, 48'd1);

        press(1'b0, 1'b1);
        chk("back_to_0_window", {46'd0, window}, 48'd0);

        // Zero blanking / leading zeros
        do_load(48'o0000_0000_0000_0050);
`ifdef SEG7_ZERO_BLANK_EN
        push_slots(S0, S5, SB, SB, 0);
`else
        push_slots(S0, S5, S0, S0, 0);
`endif
        drain();

        // Snapshot hold: value changes without load
        value = 48'o7777_7777_7777_7777;
        tick(2);
`ifdef SEG7_ZERO_BLANK_EN
        push_slots(S0, S5, SB, SB, 0);
`else
        push_slots(S0, S5, S0, S0, 0);
`endif
        drain();

        // Reset mid-scan blanks at once
        do_load(48'o7777);
        wait_an(4'b1011);
        #1 rst_n = 1'b0;
        #1;
        chk("midscan_reset_an", {44'd0, an}, 48'hF);
        chk("midscan_reset_seg", {41'd0, seg}, {41'd0, 7'h7F});
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("after_reset_an", {44'd0, an}, 48'b1110);
        chk("after_reset_seg", {41'd0, seg}, {41'd0, S0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
